// File: rtl/palindrome_pkg.sv
// palindrome_pkg
// Shared definitions for the palindrome arbiter: FSM state encoding,
// default requester count / word width, and the result counter width.
package palindrome_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int PAL_CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/palindrome_unit.sv
// palindrome_unit
// Bit-reverses a word, compares it with the original and registers the
// outcome. The registered result changes only when en is high.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   en           capture the compare result this cycle
//   data_in      word under test
//   is_pal       registered result (1 = word equals its bit reversal)
module palindrome_unit #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] data_in,
  output logic              is_pal
);

  logic [DATA_W-1:0] rev;
  logic              is_pal_d;
  logic              is_pal_q;

  // For odd widths the middle bit maps onto itself, so it never affects
  // the compare.
  always_comb begin
    rev = '0;
    for (int i = 0; i < DATA_W; i++) begin
      rev[i] = data_in[DATA_W-1-i];
    end
  end

  always_comb begin
    is_pal_d = is_pal_q;
    if (en) begin
      is_pal_d = (rev == data_in);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_pal_q <= 1'b0;
    end else begin
      is_pal_q <= is_pal_d;
    end
  end

  assign is_pal = is_pal_q;

endmodule

// File: rtl/palindrome_arbiter.sv
// palindrome_arbiter
// Round-robin arbiter sharing one palindrome check engine among NUM_REQ
// requesters. One transaction at a time: accept, evaluate, respond.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   req_valid    per-requester request valid
//   req_data     per-requester word, requester k at [k*DATA_W +: DATA_W]
//   req_ready    per-requester accept (one-hot or zero, IDLE only)
//   rsp_valid    result available (RESP state)
//   rsp_ready    consumer accepts result
//   rsp_id       requester index of the result
//   rsp_data     word that was checked
//   rsp_is_pal   word equals its own bit reversal
//   busy         FSM not IDLE
//   pal_count    saturating count of palindromic responses delivered
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | arbitrate; grant and capture the round-robin winner
// ST_EVAL | check engine registers the compare result (one cycle)
// ST_RESP | present the response until rsp_ready
module palindrome_arbiter
  import palindrome_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  parameter  int DATA_W  = DATA_W_DEF,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_is_pal,
  output logic                      busy,
  output logic [PAL_CNT_W-1:0]      pal_count
);

  localparam logic [PAL_CNT_W-1:0] PAL_MAX = {PAL_CNT_W{1'b1}};
  localparam logic [ID_W-1:0]      ID_LAST = ID_W'(NUM_REQ - 1);

  state_e               state_d,     state_q;
  logic [ID_W-1:0]      rr_ptr_d,    rr_ptr_q;
  logic [ID_W-1:0]      id_d,        id_q;
  logic [DATA_W-1:0]    data_d,      data_q;
  logic [PAL_CNT_W-1:0] pal_count_d, pal_count_q;

  logic                 grant_found;
  logic [ID_W-1:0]      grant_idx;
  logic [ID_W-1:0]      cand;
  int                   cand_i;
  logic                 unit_en;
  logic                 unit_is_pal;

  // Search starts at rr_ptr and wraps; the first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    cand_i      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_i = int'(rr_ptr_q) + i;
      if (cand_i >= NUM_REQ) begin
        cand_i = cand_i - NUM_REQ;
      end
      cand = ID_W'(cand_i);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    data_d      = data_q;
    pal_count_d = pal_count_q;
    req_ready   = '0;
    unit_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // req_ready is combinational from req_valid, so a grant is always
        // a transfer. Gated by rst_n so nothing is granted while in reset.
        if (grant_found && rst_n) begin
          req_ready[grant_idx] = 1'b1;
          id_d    = grant_idx;
          data_d  = req_data[int'(grant_idx)*DATA_W +: DATA_W];
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        unit_en = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d  = ST_IDLE;
          // Pointer moves only on completion, to the requester after the
          // one just served.
          rr_ptr_d = (id_q == ID_LAST) ? '0 : id_q + ID_W'(1);
          if (unit_is_pal && (pal_count_q != PAL_MAX)) begin
            pal_count_d = pal_count_q + PAL_CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      data_q      <= '0;
      pal_count_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      data_q      <= data_d;
      pal_count_q <= pal_count_d;
    end
  end

  palindrome_unit #(
    .DATA_W (DATA_W)
  ) u_unit (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (unit_en),
    .data_in (data_q),
    .is_pal  (unit_is_pal)
  );

  assign rsp_valid  = (state_q == ST_RESP);
  assign busy       = (state_q != ST_IDLE);
  assign rsp_id     = id_q;
  assign rsp_data   = data_q;
  assign rsp_is_pal = unit_is_pal;
  assign pal_count  = pal_count_q;

endmodule

// File: tb/tb_palindrome_arbiter.sv
// tb_palindrome_arbiter
// Directed bench with a response scoreboard: tests push the expected
// (id, data, is_pal) of every response they provoke; a monitor pops and
// compares each completed response.
module tb_palindrome_arbiter;
  import palindrome_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_is_pal;
  logic           busy;
  logic [15:0]    pal_count;

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] data;
    logic         pal;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [15:0] exp_pal;

  palindrome_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_is_pal (rsp_is_pal),
    .busy       (busy),
    .pal_count  (pal_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting, expected DUT event", name);
  endtask

  // Scoreboard monitor: every completed response must match the oldest
  // expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rsp: got id %0d data 0x%0h, expected no response",
                 rsp_id, rsp_data);
      end else begin
        e = sb_q.pop_front();
        check("rsp_id",     32'(rsp_id),     32'(e.id));
        check("rsp_data",   32'(rsp_data),   32'(e.data));
        check("rsp_is_pal", 32'(rsp_is_pal), 32'(e.pal));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int id, input logic [W-1:0] d, input logic p);
    exp_t e;
    e.id   = 2'(id);
    e.data = d;
    e.pal  = p;
    sb_q.push_back(e);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_rst_rsp_valid"},  32'(rsp_valid),  0);
    check({tag, "_rst_busy"},       32'(busy),       0);
    check({tag, "_rst_req_ready"},  32'(req_ready),  0);
    check({tag, "_rst_rsp_id"},     32'(rsp_id),     0);
    check({tag, "_rst_rsp_data"},   32'(rsp_data),   0);
    check({tag, "_rst_rsp_is_pal"}, 32'(rsp_is_pal), 0);
    check({tag, "_rst_pal_count"},  32'(pal_count),  0);
  endtask

  // Present a word on requester k and drop valid right after the accept.
  task automatic send_one(input int k, input logic [W-1:0] d);
    int t;
    req_data[k*W +: W] = d;
    req_valid[k] = 1'b1;
    t = 0;
    @(negedge clk);
    while (!req_ready[k] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready[k]) timeout("send_accept");
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb_q.size() != 0) begin
      timeout(name);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  // Drop each requester's valid right after it is granted.
  task automatic serve();
    int t;
    t = 0;
    while (req_valid != '0 && t < 200) begin
      @(negedge clk);
      t++;
      if (req_ready != '0) begin
        for (int k = 0; k < N; k++) begin
          if (req_ready[k]) begin
            @(posedge clk);
            #1;
            req_valid[k] = 1'b0;
          end
        end
      end
    end
    if (req_valid != '0) timeout("serve");
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    logic [W-1:0] t2_data [4];
    int           t2_id   [4];
    logic         t2_pal  [4];
    int           t, acc;

    t2_data = '{8'h12, 8'h01, 8'hA5, 8'h18};
    t2_id   = '{0, 3, 1, 2};
    t2_pal  = '{1'b0, 1'b0, 1'b1, 1'b1};

    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    #1;
    reset_checks("init");
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    exp_pal = 16'd0;

    // Single request: grant same cycle, response two cycles later.
    tick();
    req_data[2*W +: W] = 8'h81;
    req_valid[2] = 1'b1;
    push(2, 8'h81, 1'b1);
    @(negedge clk);
    check("t1_ready_same_cycle", 32'(req_ready), 32'h4);
    tick();
    req_valid[2] = 1'b0;
    @(negedge clk);
    check("t1_no_rsp_in_eval", 32'(rsp_valid), 0);
    check("t1_busy_eval",      32'(busy),      1);
    @(negedge clk);
    check("t1_rsp_valid", 32'(rsp_valid), 1);
    @(negedge clk);
    exp_pal = 16'd1;
    check("t1_pal_count", 32'(pal_count), 32'(exp_pal));
    check("t1_idle_busy", 32'(busy), 0);

    // Palindrome / non-palindrome words.
    for (int i = 0; i < 4; i++) begin
      tick();
      push(t2_id[i], t2_data[i], t2_pal[i]);
      send_one(t2_id[i], t2_data[i]);
      wait_drain("t2_drain");
      if (t2_pal[i]) exp_pal = sat_inc(exp_pal);
      check("t2_pal_count", 32'(pal_count), 32'(exp_pal));
    end

    // All requesters valid continuously: grants rotate from 0.
    rst_n = 1'b0;
    #1;
    reset_checks("t3");
    @(negedge clk);
    rst_n   = 1'b1;
    exp_pal = 16'd0;
    tick();
    req_data = {8'h01, 8'hA5, 8'h12, 8'h81};
    for (int r = 0; r < 2; r++) begin
      push(0, 8'h81, 1'b1);
      push(1, 8'h12, 1'b0);
      push(2, 8'hA5, 1'b1);
      push(3, 8'h01, 1'b0);
    end
    req_valid = 4'hF;
    acc = 0;
    t   = 0;
    while (acc < 8 && t < 200) begin
      @(negedge clk);
      t++;
      if (req_ready != '0) acc++;
    end
    if (acc < 8) timeout("t3_accepts");
    tick();
    req_valid = '0;
    wait_drain("t3_drain");
    exp_pal = 16'd4;
    check("t3_pal_count", 32'(pal_count), 32'(exp_pal));

    // Backpressure in RESP, then next grant goes to rsp_id+1.
    tick();
    rsp_ready = 1'b0;
    push(1, 8'h18, 1'b1);
    send_one(1, 8'h18);
    req_data  = {8'h01, 8'hA5, 8'h18, 8'h81};
    req_valid = 4'b1101;
    t = 0;
    @(negedge clk);
    while (!rsp_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!rsp_valid) timeout("t4_rsp_valid");
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 32'(rsp_valid), 1);
      check("t4_hold_rsp", {21'd0, rsp_id, rsp_data, rsp_is_pal}, {21'd0, 2'd1, 8'h18, 1'b1});
      check("t4_hold_ready0", 32'(req_ready), 0);
      @(negedge clk);
    end
    push(2, 8'hA5, 1'b1);
    push(3, 8'h01, 1'b0);
    push(0, 8'h81, 1'b1);
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t4_next_grant", 32'(req_ready), 32'h4);
    tick();
    req_valid[2] = 1'b0;
    serve();
    wait_drain("t4_drain");
    exp_pal = 16'd7;
    check("t4_pal_count", 32'(pal_count), 32'(exp_pal));

    // Reset during EVAL discards the transaction.
    tick();
    send_one(1, 8'h81);
    req_data  = {8'h01, 8'hA5, 8'h66, 8'h81};
    req_valid = 4'b0011;
    rst_n     = 1'b0;
    #1;
    reset_checks("t5");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_no_rsp_in_reset", 32'(rsp_valid), 0);
    end
    rst_n   = 1'b1;
    exp_pal = 16'd0;
    #1;
    check("t5_first_grant_r0", 32'(req_ready), 32'h1);
    push(0, 8'h81, 1'b1);
    push(1, 8'h66, 1'b1);
    tick();
    req_valid[0] = 1'b0;
    serve();
    wait_drain("t5_drain");
    exp_pal = 16'd2;
    check("t5_pal_count", 32'(pal_count), 32'(exp_pal));

    // Counter saturation.
    @(negedge clk);
    force dut.pal_count_q = 16'hFFFE;
    #1;
    release dut.pal_count_q;
    #1;
    exp_pal = 16'hFFFE;
    check("t6_preload", 32'(pal_count), 32'(exp_pal));
    for (int i = 0; i < 3; i++) begin
      tick();
      push(0, 8'h81, 1'b1);
      send_one(0, 8'h81);
      wait_drain("t6_drain");
      exp_pal = sat_inc(exp_pal);
      check("t6_pal_sat", 32'(pal_count), 32'(exp_pal));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
